// File: rtl/pipe_stage_rv.sv
// Generic valid/ready pipeline stage carrying LANES opaque fields, with optional
// skid entry (registered in_ready), synchronous flush and a saturating drop counter.
module pipe_stage_rv #(
  parameter int unsigned        DATA_W  = 32,
  parameter int unsigned        LANES   = 6,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0,
  parameter int unsigned        SKID    = 1,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int unsigned     W        = LANES * DATA_W;
  localparam logic [W-1:0]    CLR_WORD = {LANES{CLR_VAL}};

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;
  typedef enum logic [1:0] {M_HOLD, M_IN, M_SKID, M_CLR} msel_t;

  state_t         state_q, state_d;
  msel_t          main_sel;
  logic [W-1:0]   main_d;
  logic [W-1:0]   skid_d;
  logic           main_v, skid_v;
  logic           in_xfer, out_xfer;
  logic           skid_load, skid_clr;
  logic [1:0]     drop_inc;
  logic [CNT_W:0] drop_sum;
  logic [CNT_W-1:0] drop_next;

  assign main_v    = (state_q != ST_EMPTY);
  assign skid_v    = (state_q == ST_SKID);
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    main_sel  = M_HOLD;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    drop_inc  = '0;
    if (flush) begin
      // An entry leaving downstream on the flush cycle was delivered, not dropped.
      state_d   = ST_EMPTY;
      main_sel  = M_CLR;
      skid_clr  = 1'b1;
      drop_inc  = {1'b0, main_v & ~out_ready} + {1'b0, skid_v};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_sel = M_IN;
            state_d  = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_sel = M_IN;
          end else if (in_xfer && SKID != 0) begin
            skid_load = 1'b1;
            state_d   = ST_SKID;
          end else if (out_xfer) begin
            main_sel = M_CLR;
            state_d  = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            main_sel = M_SKID;
            skid_clr = 1'b1;
            state_d  = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign drop_sum  = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, drop_inc};
  assign drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      main_d   <= CLR_WORD;
      drop_cnt <= '0;
    end else begin
      state_q <= state_d;
      case (main_sel)
        M_IN:    main_d <= in_data;
        M_SKID:  main_d <= skid_d;
        M_CLR:   main_d <= CLR_WORD;
        default: main_d <= main_d;
      endcase
      if (flush) drop_cnt <= drop_next;
    end
  end

  if (SKID != 0) begin : g_skid
    assign in_ready = ~skid_v & ~flush;

    always_ff @(posedge clk) begin
      if (reset || skid_clr) skid_d <= CLR_WORD;
      else if (skid_load)    skid_d <= in_data;
    end
  end else begin : g_noskid
    logic skid_unused;
    assign in_ready    = (~main_v | out_ready) & ~flush;
    assign skid_d      = CLR_WORD;
    assign skid_unused = skid_load | skid_clr;
  end

endmodule

// File: tb/tb_pipe_stage_rv.sv
// Bench for pipe_stage_rv: skid and non-skid instances share directed stimulus and
// are each checked every cycle against a queue-based model plus literal expectations.
module tb_pipe_stage_rv;

  localparam int DW = 32;
  localparam int LN = 6;
  localparam int W  = DW * LN;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          rdy1, ov1, rdy0, ov0;
  logic [W-1:0]  od1, od0;
  logic [CW-1:0] dc1, dc0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  int cnt1 = 0;
  int cnt0 = 0;

  pipe_stage_rv #(.DATA_W(DW), .LANES(LN), .CLR_VAL(32'h0), .SKID(1), .CNT_W(CW)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .drop_cnt(dc1)
  );

  pipe_stage_rv #(.DATA_W(DW), .LANES(LN), .CLR_VAL(32'h0), .SKID(0), .CNT_W(CW)) u_noskid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .drop_cnt(dc0)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Model: a stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  initial begin : model
    bit ix1, ox1, ix0, ox0;
    forever begin
      @(posedge clk);
      ix1 = in_valid && (q1.size() < 2) && !flush;
      ox1 = (q1.size() > 0) && out_ready;
      ix0 = in_valid && ((q0.size() == 0) || out_ready) && !flush;
      ox0 = (q0.size() > 0) && out_ready;
      if (reset) begin
        q1.delete(); q0.delete(); cnt1 = 0; cnt0 = 0;
      end else if (flush) begin
        cnt1 = sat(cnt1 + (((q1.size() > 0) && !out_ready) ? 1 : 0) + ((q1.size() == 2) ? 1 : 0));
        cnt0 = sat(cnt0 + (((q0.size() > 0) && !out_ready) ? 1 : 0));
        q1.delete(); q0.delete();
      end else begin
        if (ox1) void'(q1.pop_front());
        if (ix1) q1.push_back(in_data);
        if (ox0) void'(q0.pop_front());
        if (ix0) q0.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("skid.out_valid", W'(ov1), W'(q1.size() > 0));
      chk("skid.out_data", od1, (q1.size() > 0) ? q1[0] : '0);
      chk("skid.in_ready", W'(rdy1), W'((q1.size() < 2) && !flush));
      chk("skid.drop_cnt", W'(dc1), W'(cnt1));
      chk("noskid.out_valid", W'(ov0), W'(q0.size() > 0));
      chk("noskid.out_data", od0, (q0.size() > 0) ? q0[0] : '0);
      chk("noskid.in_ready", W'(rdy0), W'(((q0.size() == 0) || out_ready) && !flush));
      chk("noskid.drop_cnt", W'(dc0), W'(cnt0));
    end
  end

  task automatic set_in(input bit r, input bit f, input bit v, input logic [31:0] d0, input bit o);
    reset = r; flush = f; in_valid = v; out_ready = o;
    for (int k = 0; k < LN; k++) in_data[k*DW +: DW] = d0 + 32'(k) * 32'h0001_0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] addrs [4];

  initial begin
    addrs = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    set_in(1, 0, 0, 0, 1);
    tick(); tick();
    chk_en = 1'b1;
    chk("rst.skid.out_valid", W'(ov1), W'(0));
    chk("rst.skid.out_data", od1, W'(0));
    chk("rst.skid.drop_cnt", W'(dc1), W'(0));
    chk("rst.noskid.out_data", od0, W'(0));
    set_in(0, 0, 0, 0, 1); #1;
    chk("rst.skid.in_ready", W'(rdy1), W'(1));
    chk("rst.noskid.in_ready", W'(rdy0), W'(1));

    // Back-to-back stream, 1-cycle latency
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 1, addrs[i], 1); #1;
      chk("stream.skid.in_ready", W'(rdy1), W'(1));
      tick();
      chk("stream.skid.lane0", W'(od1[31:0]), W'(addrs[i]));
      chk("stream.noskid.lane0", W'(od0[31:0]), W'(addrs[i]));
      chk("stream.skid.out_valid", W'(ov1), W'(1));
    end
    chk("stream.skid.lane5", W'(od1[5*DW +: DW]), W'(32'h0005_100C));
    set_in(0, 0, 0, 0, 1); tick();
    chk("drain.skid.out_valid", W'(ov1), W'(0));
    chk("drain.skid.out_data", od1, W'(0));

    // Skid capture under stall, then in-order release
    set_in(0, 0, 1, 32'h5, 0); tick();
    set_in(0, 0, 1, 32'hA, 0); #1;
    chk("stall.skid.in_ready", W'(rdy1), W'(1));
    chk("stall.noskid.in_ready", W'(rdy0), W'(0));
    tick();
    set_in(0, 0, 0, 0, 0); #1;
    chk("skid.in_ready_low", W'(rdy1), W'(0));
    chk("skid.main_kept", W'(od1[31:0]), W'(32'h5));
    set_in(0, 0, 0, 0, 1); #1;
    chk("release.skid.in_ready", W'(rdy1), W'(0));
    tick();
    chk("release.skid.second", W'(od1[31:0]), W'(32'hA));
    chk("release.noskid.empty", W'(ov0), W'(0));
    chk("release.skid.in_ready_back", W'(rdy1), W'(1));
    tick();
    chk("release.skid.empty", W'(ov1), W'(0));

    // Non-skid replacement on the same cycle
    set_in(0, 0, 1, 32'h20, 0); tick();
    set_in(0, 0, 1, 32'h24, 1); #1;
    chk("replace.noskid.in_ready", W'(rdy0), W'(1));
    tick();
    chk("replace.noskid.lane0", W'(od0[31:0]), W'(32'h24));
    chk("replace.noskid.out_valid", W'(ov0), W'(1));

    // Flush with both entries held
    set_in(0, 0, 1, 32'h30, 0); tick();
    set_in(0, 1, 1, 32'h40, 0); #1;
    chk("flush.skid.in_ready", W'(rdy1), W'(0));
    chk("flush.noskid.in_ready", W'(rdy0), W'(0));
    tick();
    chk("flush.skid.drop", W'(dc1), W'(2));
    chk("flush.noskid.drop", W'(dc0), W'(1));
    chk("flush.skid.out_valid", W'(ov1), W'(0));
    chk("flush.skid.out_data", od1, W'(0));

    // Flush while delivering: nothing dropped
    set_in(0, 0, 1, 32'h50, 1); tick();
    set_in(0, 1, 0, 0, 1); tick();
    chk("flushdeliv.skid.drop", W'(dc1), W'(2));
    chk("flushdeliv.noskid.drop", W'(dc0), W'(1));

    // Saturation
    for (int i = 0; i < 300; i++) begin
      set_in(0, 0, 1, 32'h100 + 32'(i), 0); tick();
      set_in(0, 1, 0, 0, 0); tick();
      if (i == 252) begin
        chk("sat.skid.edge", W'(dc1), W'(255));
        chk("sat.noskid.edge", W'(dc0), W'(254));
      end
    end
    chk("sat.skid.final", W'(dc1), W'(255));
    chk("sat.noskid.final", W'(dc0), W'(255));

    // Mid-stream reset
    set_in(0, 0, 1, 32'h60, 0); tick();
    set_in(0, 0, 1, 32'h64, 0); tick();
    set_in(1, 0, 1, 32'h68, 0); tick();
    chk("mrst.skid.out_valid", W'(ov1), W'(0));
    chk("mrst.skid.drop", W'(dc1), W'(0));
    chk("mrst.noskid.drop", W'(dc0), W'(0));
    chk("mrst.noskid.out_data", od0, W'(0));
    set_in(0, 0, 0, 0, 0); #1;
    chk("mrst.skid.in_ready", W'(rdy1), W'(1));
    chk("mrst.noskid.in_ready", W'(rdy0), W'(1));
    set_in(0, 0, 1, 32'h70, 1); tick();
    chk("mrst.skid.lane0", W'(od1[31:0]), W'(32'h70));

    // Mixed valid/ready pattern with one flush, model-checked
    for (int i = 0; i < 40; i++) begin
      set_in(0, i == 17, (i % 3) != 0, 32'h2000 + 32'(i) * 4, (i % 4) != 1);
      tick();
    end
    set_in(0, 0, 0, 0, 1); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_rv.md
Name: pipe_stage_rv

Overview:
- Parametrised successor to the fixed D->E stage registers: one generic pipeline stage carrying LANES fields of DATA_W bits each.
- Adds a valid/ready handshake, an optional one-entry skid buffer so upstream ready is fully registered, and a synchronous flush that inserts a bubble.
- Counts valid entries discarded by flushes.
- Instantiated between any two pipeline stages (F/D, D/E, E/M, M/W) in place of the hand-written stage registers.

Parameters:
- DATA_W, 32, width of one lane (instr, PC, PC8, RD1, RD2, imm32 each one lane).
- LANES, 6, number of lanes carried.
- CLR_VAL, 0, value every lane takes on reset, flush or drain (0 = nop bubble).
- SKID, 1, 1 = two-entry skid mode with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 8, width of drop counter.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; same effect as flush, and also clears drop_cnt.
- flush  in  1  synchronous clear of the stage contents (branch/exception kill).
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_data  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W].
- out_valid  out  1  out_data is a valid entry.
- out_ready  in  1  downstream accepts this cycle (low = stall).
- out_data  out  LANES*DATA_W  registered; always equal to the main register.
- drop_cnt  out  CNT_W  saturating count of valid entries discarded by flush.

Behaviour:
- Transfers:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
  - No combinational path from in_data to out_data.
- Storage:
  - Main register (main_v, main_d).
  - With SKID=1, also a skid register (skid_v, skid_d).
  - out_valid = main_v; out_data = main_d.
- SKID=1:
  - in_ready = ~skid_v AND ~flush, i.e. registered state gated by flush.
  - States: EMPTY (main_v=0), FULL (main_v=1, skid_v=0), SKID (both 1).
  - EMPTY: in_xfer -> main_d<=in_data, FULL; else stay, main_d holds CLR_VAL.
  - FULL, in_xfer & out_xfer: main_d<=in_data, stay FULL.
  - FULL, in_xfer & ~out_xfer: skid_d<=in_data, go SKID; main_d unchanged.
  - FULL, ~in_xfer & out_xfer: main_d<=CLR_VAL, main_v<=0, go EMPTY.
  - FULL, neither: hold.
  - SKID: in_ready=0. out_xfer -> main_d<=skid_d, skid_d<=CLR_VAL, go FULL; else hold.
- SKID=0:
  - in_ready = (~main_v | out_ready) & ~flush.
  - Same transitions as above without the SKID state.
  - Skid register is not instantiated.
- Flush (evaluated before all of the above):
  - main_v, skid_v <= 0; main_d, skid_d <= CLR_VAL; state EMPTY.
  - in_ready is 0 during flush, so a same-cycle input is never accepted.
  - A same-cycle out_xfer still counts as delivered downstream; the entry is not counted as dropped.
  - drop_cnt += (main_v & ~out_ready) + skid_v, saturating at 2^CNT_W-1.
- Reset:
  - Identical to flush, plus drop_cnt<=0.
  - Takes priority over flush.
  - Mid-operation reset discards both entries without counting them.
- After reset, all outputs: out_valid=0, out_data=all lanes CLR_VAL, in_ready=1 (when flush=0), drop_cnt=0.
- Latency: 1 cycle from in_xfer to out_valid when the stage is empty. Throughput 1 entry/cycle while out_ready=1.
- Ordering: strict FIFO; the skid entry is always older than any later input.
- Lanes are opaque; no arithmetic on data. drop_cnt never wraps.

Test Plan:
- Reset, then stream 4 entries (lane0 = 0x1000, 0x1004, 0x1008, 0x100C) with out_ready=1 -> each appears exactly 1 cycle after input, in_ready stays 1, no gaps.
- SKID=1: FULL with out_ready=0, in_valid=1 data 0xA -> skid captures 0xA, in_ready=0 next cycle. Raise out_ready -> old main then 0xA delivered in order; in_ready returns to 1 the cycle after SKID empties.
- FULL drains with no new input -> out_valid=0 and every lane of out_data = CLR_VAL (0x00000000) the next cycle.
- SKID state, out_ready=0, flush=1 with in_valid=1 -> next cycle out_valid=0, lanes = 0, input not captured, drop_cnt +2.
- Flush in FULL with out_ready=1 -> drop_cnt unchanged. Force 300 dropping flushes with CNT_W=8 -> drop_cnt saturates at 255.
- SKID=0: FULL with out_ready=0 -> in_ready=0 combinationally. out_ready=1 with in_valid=1 -> replacement accepted the same cycle. Reset asserted mid-stream -> all state cleared next edge, drop_cnt=0.
